alu_result_stage: RTL and testbench

Registered output stage directly downstream of `alu32`: captures the ALU result and flags with a destination tag, resolves the branch condition from the flags, and presents the entry to the memory stage over a valid/ready handshake. A two-entry skid buffer (main and skid) keeps one-per-cycle throughput. `in_ready` is driven from a register, so downstream back-pressure never creates a combinational path into the ALU or decode.

---
 rtl/alu_result_stage.sv | 192 +++++++++++++++++++
 tb/tb_alu_result_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered output stage behind alu32.
// Captures the ALU result, destination tag and resolved branch decision into a
// two-entry skid buffer (main + skid) and hands entries to the memory stage
// over a valid/ready handshake. in_ready comes from a flop, so back-pressure
// from the memory stage never reaches the ALU or decode combinationally.
// Optional feature macro: ALU_STAGE_OVF_TRAP_EN (stores a per-entry overflow
// trap bit; when undefined out_ovf_trap is tied low and no bit is stored).
module alu_result_stage #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_result,
    input  logic             in_cout,
    input  logic             in_overflow,
    input  logic             in_zero,
    input  logic [TAG_W-1:0] in_rd,
    input  logic             in_is_branch,
    input  logic [2:0]       in_funct3,
    input  logic             in_chk_ovf,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_rd,
    output logic             out_br_taken,
    output logic             out_ovf_trap
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic in_xfer;
    logic out_xfer;
    logic br_cond;
    logic br_taken_in;

    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    logic [31:0]      skid_result;
    logic [TAG_W-1:0] skid_rd;
    logic             skid_br;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Branch condition from the ALU flags; slt/sltu results carry the compare in bit 0
    always_comb begin
        br_cond = 1'b0;
        case (in_funct3)
            3'b000:  br_cond = in_zero;
            3'b001:  br_cond = !in_zero;
            3'b100,
            3'b110:  br_cond = in_result[0];
            3'b101,
            3'b111:  br_cond = !in_result[0];
            default: br_cond = 1'b0;
        endcase
    end

    assign br_taken_in = in_is_branch && br_cond;

    // Next-state and load decode; flush overrides every other event
    always_comb begin
        next_state     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        next_state   = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        load_main_in = 1'b1;
                    end else if (in_xfer) begin
                        next_state = FULL;
                        load_skid  = 1'b1;
                    end else if (out_xfer) begin
                        next_state = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        next_state     = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: begin
                    next_state = EMPTY;
                end
            endcase
        end
    end

    // Occupancy state with registered handshake outputs derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= next_state;
            out_valid <= (next_state != EMPTY);
            in_ready  <= (next_state != FULL);
        end
    end

    // Main entry register: takes the input directly or promotes the skid entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result   <= 32'd0;
            out_rd       <= '0;
            out_br_taken <= 1'b0;
        end else if (load_main_in) begin
            out_result   <= in_result;
            out_rd       <= in_rd;
            out_br_taken <= br_taken_in;
        end else if (load_main_skid) begin
            out_result   <= skid_result;
            out_rd       <= skid_rd;
            out_br_taken <= skid_br;
        end
    end

    // Skid entry register: parks an input accepted while the main entry is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_result <= 32'd0;
            skid_rd     <= '0;
            skid_br     <= 1'b0;
        end else if (load_skid) begin
            skid_result <= in_result;
            skid_rd     <= in_rd;
            skid_br     <= br_taken_in;
        end
    end

`ifdef ALU_STAGE_OVF_TRAP_EN
    logic ovf_in;
    logic main_ovf;
    logic skid_ovf;

    // The result is passed through untouched; only the trap bit marks the entry
    assign ovf_in       = in_chk_ovf && in_overflow;
    assign out_ovf_trap = main_ovf;

    // Trap bits travel alongside the main and skid entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_ovf <= 1'b0;
            skid_ovf <= 1'b0;
        end else begin
            if (load_main_in) begin
                main_ovf <= ovf_in;
            end else if (load_main_skid) begin
                main_ovf <= skid_ovf;
            end
            if (load_skid) begin
                skid_ovf <= ovf_in;
            end
        end
    end

    // Carry-out is not needed by this stage
    logic unused_flags;
    assign unused_flags = in_cout;
`else
    assign out_ovf_trap = 1'b0;

    // Flags that only matter when the overflow trap is built in
    logic unused_flags;
    assign unused_flags = in_cout ^ in_overflow ^ in_chk_ovf;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed, table-driven bench for alu_result_stage.
// Covers reset values, async reset mid-stream, back-pressure through the skid
// entry, streaming, branch resolution, flush in FULL and the overflow trap bit
// (expectation follows ALU_STAGE_OVF_TRAP_EN).
module tb_alu_result_stage;

    localparam int TAG_W = 5;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_result;
    logic             in_cout;
    logic             in_overflow;
    logic             in_zero;
    logic [TAG_W-1:0] in_rd;
    logic             in_is_branch;
    logic [2:0]       in_funct3;
    logic             in_chk_ovf;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_rd;
    logic             out_br_taken;
    logic             out_ovf_trap;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic        is_branch;
        logic [2:0]  funct3;
        logic        exp_br;
    } vec_t;

    vec_t vecs[10];

    alu_result_stage #(.TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_cout      (in_cout),
        .in_overflow  (in_overflow),
        .in_zero      (in_zero),
        .in_rd        (in_rd),
        .in_is_branch (in_is_branch),
        .in_funct3    (in_funct3),
        .in_chk_ovf   (in_chk_ovf),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_rd       (out_rd),
        .out_br_taken (out_br_taken),
        .out_ovf_trap (out_ovf_trap)
    );

    // Free-running clock, 10 ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] result,
                                 input logic [TAG_W-1:0] rd, input logic rdy);
        in_valid  = valid;
        in_result = result;
        in_rd     = rd;
        out_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_result    = 32'd0;
        in_cout      = 1'b0;
        in_overflow  = 1'b0;
        in_zero      = 1'b0;
        in_rd        = '0;
        in_is_branch = 1'b0;
        in_funct3    = 3'd0;
        in_chk_ovf   = 1'b0;
        flush        = 1'b0;
        out_ready    = 1'b0;

        vecs[0] = '{32'h0000_0000, 1'b1, 1'b1, 3'b000, 1'b1};
        vecs[1] = '{32'h0000_0000, 1'b1, 1'b1, 3'b001, 1'b0};
        vecs[2] = '{32'h0000_0001, 1'b0, 1'b1, 3'b100, 1'b1};
        vecs[3] = '{32'h0000_0001, 1'b0, 1'b1, 3'b111, 1'b0};
        vecs[4] = '{32'h0000_0000, 1'b1, 1'b0, 3'b000, 1'b0};
        vecs[5] = '{32'h0000_0004, 1'b0, 1'b1, 3'b001, 1'b1};
        vecs[6] = '{32'h0000_0000, 1'b1, 1'b1, 3'b101, 1'b1};
        vecs[7] = '{32'h0000_0002, 1'b1, 1'b1, 3'b110, 1'b0};
        vecs[8] = '{32'h0000_0001, 1'b1, 1'b1, 3'b010, 1'b0};
        vecs[9] = '{32'h0000_0006, 1'b0, 1'b1, 3'b000, 1'b0};

        // Reset values
        repeat (2) tick();
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_result", out_result, 0);
        checkOutput("rst_out_rd", out_rd, 0);
        checkOutput("rst_out_br", out_br_taken, 0);
        checkOutput("rst_out_ovf", out_ovf_trap, 0);
        rst_n = 1'b1;
        tick();

        // First entry: 5 -> rd 3, visible after one edge
        applyStimulus(1'b1, 32'h5, 5'd3, 1'b0);
        tick();
        checkOutput("first_valid", out_valid, 1);
        checkOutput("first_result", out_result, 32'h5);
        checkOutput("first_rd", out_rd, 3);
        checkOutput("first_in_ready", in_ready, 1);

        // Fill the skid entry, then reset asynchronously mid-stream
        applyStimulus(1'b1, 32'h9, 5'd4, 1'b0);
        tick();
        checkOutput("full_in_ready", in_ready, 0);
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", out_valid, 0);
        checkOutput("async_rst_in_ready", in_ready, 1);
        checkOutput("async_rst_result", out_result, 0);
        #1;
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_valid", out_valid, 0);

        // Back-pressure: A then B with out_ready low
        applyStimulus(1'b1, 32'h11, 5'd1, 1'b0);
        tick();
        checkOutput("bp_a_valid", out_valid, 1);
        checkOutput("bp_a_in_ready", in_ready, 1);
        applyStimulus(1'b1, 32'h22, 5'd2, 1'b0);
        tick();
        checkOutput("bp_b_in_ready", in_ready, 0);
        checkOutput("bp_hold_a", out_result, 32'h11);
        // Input offered while FULL must be ignored
        applyStimulus(1'b1, 32'h33, 5'd7, 1'b0);
        tick();
        checkOutput("bp_full_in_ready", in_ready, 0);
        checkOutput("bp_full_hold_a", out_result, 32'h11);
        checkOutput("bp_full_hold_rd", out_rd, 1);
        // Release: A leaves, B moves to main
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b1);
        tick();
        checkOutput("bp_b_valid", out_valid, 1);
        checkOutput("bp_b_result", out_result, 32'h22);
        checkOutput("bp_b_rd", out_rd, 2);
        checkOutput("bp_ready_back", in_ready, 1);
        tick();
        checkOutput("bp_drained", out_valid, 0);
        checkOutput("bp_drained_hold", out_result, 32'h22);

        // Streaming: 16 back-to-back entries at 1-cycle latency
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 32'(i), TAG_W'(i), 1'b1);
            tick();
            checkOutput($sformatf("stream_valid_%0d", i), out_valid, 1);
            checkOutput($sformatf("stream_result_%0d", i), out_result, 32'(i));
            checkOutput($sformatf("stream_rd_%0d", i), out_rd, 32'(i));
            checkOutput($sformatf("stream_ready_%0d", i), in_ready, 1);
        end
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b1);
        tick();
        checkOutput("stream_end_valid", out_valid, 0);

        // Branch resolution table
        for (int i = 0; i < 10; i++) begin
            in_zero      = vecs[i].zero;
            in_is_branch = vecs[i].is_branch;
            in_funct3    = vecs[i].funct3;
            applyStimulus(1'b1, vecs[i].result, TAG_W'(i + 8), 1'b1);
            tick();
            checkOutput($sformatf("br_taken_%0d", i), out_br_taken, vecs[i].exp_br);
            checkOutput($sformatf("br_result_%0d", i), out_result, vecs[i].result);
        end
        in_zero      = 1'b0;
        in_is_branch = 1'b0;
        in_funct3    = 3'd0;
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b1);
        tick();

        // Flush in FULL together with a new input
        applyStimulus(1'b1, 32'hA1, 5'd10, 1'b0);
        tick();
        applyStimulus(1'b1, 32'hA2, 5'd11, 1'b0);
        tick();
        checkOutput("fl_full", in_ready, 0);
        applyStimulus(1'b1, 32'hA3, 5'd12, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("fl_valid", out_valid, 0);
        checkOutput("fl_in_ready", in_ready, 1);
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("fl_gone_%0d", i), out_valid, 0);
        end

        // Overflow trap: 0x7FFFFFFF + 1
        in_overflow = 1'b1;
        in_chk_ovf  = 1'b1;
        applyStimulus(1'b1, 32'h8000_0000, 5'd5, 1'b1);
        tick();
        in_overflow = 1'b0;
        in_chk_ovf  = 1'b0;
        checkOutput("ovf_valid", out_valid, 1);
        checkOutput("ovf_result", out_result, 32'h8000_0000);
`ifdef ALU_STAGE_OVF_TRAP_EN
        checkOutput("ovf_trap", out_ovf_trap, 1);
`else
        checkOutput("ovf_trap", out_ovf_trap, 0);
`endif
        // Next entry without overflow clears the trap bit
        applyStimulus(1'b1, 32'h1, 5'd6, 1'b1);
        tick();
        checkOutput("ovf_clear", out_ovf_trap, 0);
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
